union_frame_loader: RTL
=======================

Name: union_frame_loader

Overview:
- Sequences the packed frame resource `my_packed_struct_t [K:0][J:0]`: 3x4 elements of 3-bit {a,b,c}, 36 bits total.
- Accepts one 3-bit element per cycle over a valid/ready stream and assembles full frames into two ping-pong banks.
- Presents each completed frame whole over a second valid/ready handshake.
- Sits between an element producer and any consumer of `my_packed_union_with_array_t`; the consumer may view `out_frame` through either union member.

Parameters:
- J, 3, highest column index (from shared package)
- K, 2, highest row index (from shared package)
- CNT_W, 8, width of delivered-frame counter

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer element valid
- in_ready  output  1  loader can accept element
- in_data  input  3  `my_packed_struct_t` element {a,b,c}
- abort  input  1  discard partially filled frame in write bank
- out_valid  output  1  completed frame available
- out_ready  input  1  consumer accepts frame
- out_frame  output  36  `my_packed_struct_t [K:0][J:0]` of read bank
- out_bank  output  1  index of bank being presented
- fill_row  output  2  current write row (0..K)
- fill_col  output  2  current write column (J..0)
- frame_cnt  output  CNT_W  frames delivered, wraps modulo 2^CNT_W

Behaviour:
- One clock; reset synchronous and active-high; ports named `clk`, `rst`.
- Reset state:
  - both banks EMPTY, bank data 0, wp=0, rp=0
  - fill_row=0, fill_col=J, frame_cnt=0, out_valid=0, out_bank=0
  - in_ready=0 while rst high, 1 on the first cycle after.
- Per-bank state machine: EMPTY -> FILLING (first element accepted) -> FULL (last element accepted) -> EMPTY (frame consumed). FILLING -> EMPTY on abort.
- Fill order:
  - row 0 first, rows ascending to K
  - within a row, column J first, descending to 0
  - accepted element stored at bank[wp][fill_row][fill_col].
  - Streaming 111,000,101,010 therefore gives row0 = 12'b111000101010.
- Counters:
  - on accept, fill_col decrements
  - at col 0 it wraps to J and fill_row increments
  - at row K, col 0 the frame completes: bank[wp] becomes FULL, wp toggles, counters return to row 0, col J.
- in_ready = !abort && bank[wp] != FULL. Accept = in_valid && in_ready.
- abort:
  - clears fill counters and returns bank[wp] to EMPTY; data is not cleared.
  - blocks acceptance that cycle.
  - has no effect on a FULL bank or on the read side.
- Read side:
  - out_valid = (bank[rp] == FULL); out_frame = bank[rp] data; out_bank = rp.
  - out_frame is stable while out_valid && !out_ready.
  - on out_valid && out_ready: bank[rp] becomes EMPTY, rp toggles, frame_cnt increments.
- Latency: last element accepted in cycle n -> out_valid in cycle n+1 if rp points to that bank.
- Simultaneous events:
  - completion on bank X and consumption of bank Y in the same cycle are both honoured.
  - with both banks FULL, in_ready=0 until a consume; in_ready rises in the cycle after the consume.
  - abort and consume in the same cycle are independent.
- Reset mid-frame or mid-handshake discards everything; no partial frame survives.

Decomposition:
- Shared package `pkg` holds:
  - J, K, `my_packed_struct_t`, `my_packed_union_with_array_t`
  - new typedefs: `frame_t` (= `my_packed_struct_t [K:0][J:0]`) and `bank_state_e` {EMPTY, FILLING, FULL}
- One natural sub-module, `frame_fill_counter`: the row/col counter with wrap, last-element flag and clear.
- Bank storage and handshakes stay in the top.

Test Plan:
- Fill one frame:
  - stimulus: row0 111,000,101,010; row1 101,010,111,000; row2 all 000, in_valid held high.
  - response: out_valid next cycle; out_frame[0]=12'b111000101010; out_frame[1]=12'b101010111000; out_frame[2]=0; out_bank=0.
- Back-pressure:
  - stimulus: out_ready=0, stream 24 elements (two frames), then a 25th offered.
  - response: both banks FULL; in_ready=0 for the 25th.
  - then pulse out_ready: frame_cnt=1, out_bank=1, in_ready=1 the following cycle.
- Abort:
  - stimulus: 5 elements accepted, then abort with in_valid=1.
  - response: element not accepted; fill_row=0, fill_col=3; next 12 elements form a clean frame matching the stimulus.
- Concurrent:
  - stimulus: last element of bank 1 and consume of bank 0 in the same cycle.
  - response: next cycle out_valid=1, out_bank=1, frame_cnt incremented by exactly 1.
- Counter wrap:
  - stimulus: deliver 256 frames.
  - response: frame_cnt returns to 0; no lost or duplicated frames.
- Reset mid-fill:
  - stimulus: assert rst after 7 elements with one bank FULL.
  - response: next cycle out_valid=0, fill_row=0, fill_col=3, frame_cnt=0, in_ready=1 after rst drops.

Source files
------------

// File: rtl/union_frame_loader_pkg.sv
// Shared types for the frame loader.
//
// A frame is a K+1 by J+1 grid of 3-bit {a,b,c} elements (3x4 = 36 bits).
// Row r of a frame occupies bits [r*12 +: 12]. Within a row, column J is
// the most significant element. Consumers may reinterpret a frame through
// my_packed_union_with_array_t, either element-wise or as flat 12-bit rows.
package union_frame_loader_pkg;

  localparam int J = 3;
  localparam int K = 2;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } my_packed_struct_t;

  typedef my_packed_struct_t [K:0][J:0] frame_t;

  localparam int ELEM_W    = $bits(my_packed_struct_t);
  localparam int ROW_BITS  = (J + 1) * ELEM_W;
  localparam int FRAME_W   = $bits(frame_t);
  localparam int ROW_IDX_W = $clog2(K + 1);
  localparam int COL_IDX_W = $clog2(J + 1);

  typedef union packed {
    frame_t                     elems;
    logic [K:0][ROW_BITS-1:0]   rows;
  } my_packed_union_with_array_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/union_frame_loader_fill.sv
// frame_fill_counter: write-position counter for one frame.
//
// Walks rows 0..K ascending and, within each row, columns J..0 descending.
// `last` flags the final position (row K, column 0); advancing from there
// returns to the start (row 0, column J). `clr` restarts the frame and
// takes priority over `adv`.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       return to row 0, column J
//   adv       step to the next position
//   row, col  current write position
//   last      current position is the final element of the frame
module frame_fill_counter
  import union_frame_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 adv,
  output logic [ROW_IDX_W-1:0] row,
  output logic [COL_IDX_W-1:0] col,
  output logic                 last
);

  localparam logic [ROW_IDX_W-1:0] ROW_LAST  = ROW_IDX_W'(K);
  localparam logic [COL_IDX_W-1:0] COL_FIRST = COL_IDX_W'(J);

  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic [COL_IDX_W-1:0] col_q, col_d;

  assign last = (row_q == ROW_LAST) && (col_q == '0);
  assign row  = row_q;
  assign col  = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = COL_FIRST;
    end else if (adv) begin
      if (col_q == '0) begin
        col_d = COL_FIRST;
        row_d = last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= COL_FIRST;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/union_frame_loader.sv
// union_frame_loader: assembles a stream of 3-bit elements into whole
// frames held in two ping-pong banks and hands each completed frame to a
// consumer over a valid/ready handshake.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_valid   producer has an element on in_data
//   in_ready   loader can accept an element this cycle
//   in_data    element {a,b,c}
//   abort      drop the partially filled frame in the write bank
//   out_valid  the read bank holds a completed frame
//   out_ready  consumer takes the presented frame
//   out_frame  contents of the read bank
//   out_bank   index of the read bank
//   fill_row   row of the next write
//   fill_col   column of the next write
//   frame_cnt  frames delivered, wrapping
module union_frame_loader
  import union_frame_loader_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ELEM_W-1:0]    in_data,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_W-1:0]   out_frame,
  output logic                 out_bank,
  output logic [ROW_IDX_W-1:0] fill_row,
  output logic [COL_IDX_W-1:0] fill_col,
  output logic [CNT_W-1:0]     frame_cnt
);

  bank_state_e bank_st_q   [2];
  bank_state_e bank_st_d   [2];
  frame_t      bank_data_q [2];
  frame_t      bank_data_d [2];
  logic        wp_q, wp_d;
  logic        rp_q, rp_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic accept;
  logic consume;
  logic fill_last;

  // in_ready is held low during reset so nothing is taken on that edge.
  assign in_ready  = !rst && !abort && (bank_st_q[wp_q] != FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (bank_st_q[rp_q] == FULL);
  assign consume   = out_valid && out_ready;

  assign out_frame = bank_data_q[rp_q];
  assign out_bank  = rp_q;
  assign frame_cnt = frame_cnt_q;

  // Clearing on abort is harmless when the write bank is FULL: the
  // counter is already at its start position in that case.
  frame_fill_counter u_fill (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .adv  (accept),
    .row  (fill_row),
    .col  (fill_col),
    .last (fill_last)
  );

  // Write and read sides never touch the same bank in one cycle: an accept
  // needs bank[wp] non-FULL while a consume needs bank[rp] FULL.
  always_comb begin
    bank_st_d   = bank_st_q;
    bank_data_d = bank_data_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    frame_cnt_d = frame_cnt_q;

    if (abort && (bank_st_q[wp_q] == FILLING)) begin
      bank_st_d[wp_q] = EMPTY;
    end

    if (accept) begin
      bank_data_d[wp_q][fill_row][fill_col] = my_packed_struct_t'(in_data);
      if (fill_last) begin
        bank_st_d[wp_q] = FULL;
        wp_d            = ~wp_q;
      end else begin
        bank_st_d[wp_q] = FILLING;
      end
    end

    if (consume) begin
      bank_st_d[rp_q] = EMPTY;
      rp_d            = ~rp_q;
      frame_cnt_d     = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0]   <= EMPTY;
      bank_st_q[1]   <= EMPTY;
      bank_data_q[0] <= '0;
      bank_data_q[1] <= '0;
      wp_q           <= 1'b0;
      rp_q           <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      bank_st_q      <= bank_st_d;
      bank_data_q    <= bank_data_d;
      wp_q           <= wp_d;
      rp_q           <= rp_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

endmodule
